// File: rtl/vga_display_if.sv
// Pixel-scan bundle between the VGA controller and the object renderers.
// test_mode exists only when VGA_TEST_PATTERN_EN is defined.
interface vga_display_if;
  logic       pacman_fill;
  logic       ghost_fill;
  logic       wall_fill;
  logic       pellet_fill;
`ifdef VGA_TEST_PATTERN_EN
  logic       test_mode;
`endif
  logic [9:0] hCount;
  logic [9:0] vCount;
  logic       pix_en;
  logic       hSync;
  logic       vSync;
  logic       bright;
  logic [3:0] vga_r;
  logic [3:0] vga_g;
  logic [3:0] vga_b;
  logic       frame_tick;

  modport master (
    input  pacman_fill,
    input  ghost_fill,
    input  wall_fill,
    input  pellet_fill,
`ifdef VGA_TEST_PATTERN_EN
    input  test_mode,
`endif
    output hCount,
    output vCount,
    output pix_en,
    output hSync,
    output vSync,
    output bright,
    output vga_r,
    output vga_g,
    output vga_b,
    output frame_tick
  );

  modport slave (
    output pacman_fill,
    output ghost_fill,
    output wall_fill,
    output pellet_fill,
`ifdef VGA_TEST_PATTERN_EN
    output test_mode,
`endif
    input  hCount,
    input  vCount,
    input  pix_en,
    input  hSync,
    input  vSync,
    input  bright,
    input  vga_r,
    input  vga_g,
    input  vga_b,
    input  frame_tick
  );
endinterface

// File: rtl/vga_display_ctrl.sv
// VGA scan generator, fill-priority colour resolve and frame tick.
// Define VGA_TEST_PATTERN_EN to add test_mode eight-bar colour pattern.
module vga_display_ctrl #(
  parameter int DIV         = 4,
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_VIS_START = 144,
  parameter int H_VIS_END   = 783,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_VIS_START = 35,
  parameter int V_VIS_END   = 514
) (
  input  logic          clk,
  input  logic          reset,
  vga_display_if.master vif
);

  localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]    HS_W     = 10'(H_SYNC);
  localparam logic [9:0]    VS_W     = 10'(V_SYNC);
  localparam logic [9:0]    HV_S     = 10'(H_VIS_START);
  localparam logic [9:0]    HV_E     = 10'(H_VIS_END);
  localparam logic [9:0]    VV_S     = 10'(V_VIS_START);
  localparam logic [9:0]    VV_E     = 10'(V_VIS_END);

  logic [DW-1:0] div_q, div_d;
  logic          pix_en_q, pix_en_d;
  logic [9:0]    hcount_q, hcount_d;
  logic [9:0]    vcount_q, vcount_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          bright_q, bright_d;
  logic [11:0]   rgb_q, rgb_d;

  logic          h_last, v_last;
  logic          hs_n, vs_n, vis;
  logic [11:0]   rgb_c;

  assign h_last = (hcount_q == H_LAST);
  assign v_last = (vcount_q == V_LAST);

  assign hs_n = !(hcount_q < HS_W);
  assign vs_n = !(vcount_q < VS_W);
  assign vis  = (hcount_q >= HV_S) && (hcount_q <= HV_E) &&
                (vcount_q >= VV_S) && (vcount_q <= VV_E);

`ifdef VGA_TEST_PATTERN_EN
  logic [9:0] rel;
  logic [2:0] bar;

  // Bars are 80 columns wide, so the index comes from band compares.
  always_comb begin
    rel = hcount_q - HV_S;
    bar = '0;
    for (int i = 1; i < 8; i++) begin
      if (rel >= 10'(80 * i)) bar = 3'(i);
    end
  end
`endif

  always_comb begin
    rgb_c = '0;
    if (!vis) begin
      rgb_c = '0;
`ifdef VGA_TEST_PATTERN_EN
    end else if (vif.test_mode) begin
      rgb_c = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
`endif
    end else if (vif.pacman_fill) begin
      rgb_c = 12'hFF0;
    end else if (vif.ghost_fill) begin
      rgb_c = 12'hF00;
    end else if (vif.wall_fill) begin
      rgb_c = 12'h00F;
    end else if (vif.pellet_fill) begin
      rgb_c = 12'hFFF;
    end
  end

  always_comb begin
    div_d    = div_q + DW'(1);
    pix_en_d = (div_q == DIV_LAST);
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    bright_d = bright_q;
    rgb_d    = rgb_q;
    if (div_q == DIV_LAST) div_d = '0;
    // Decode and fills share this edge, so outputs trail counters by 1 px.
    if (pix_en_q) begin
      hsync_d  = hs_n;
      vsync_d  = vs_n;
      bright_d = vis;
      rgb_d    = rgb_c;
      if (h_last) begin
        hcount_d = '0;
        vcount_d = v_last ? 10'd0 : vcount_q + 10'd1;
      end else begin
        hcount_d = hcount_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q    <= '0;
      pix_en_q <= 1'b0;
      hcount_q <= '0;
      vcount_q <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      bright_q <= 1'b0;
      rgb_q    <= '0;
    end else begin
      div_q    <= div_d;
      pix_en_q <= pix_en_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      bright_q <= bright_d;
      rgb_q    <= rgb_d;
    end
  end

  assign vif.hCount     = hcount_q;
  assign vif.vCount     = vcount_q;
  assign vif.pix_en     = pix_en_q;
  assign vif.hSync      = hsync_q;
  assign vif.vSync      = vsync_q;
  assign vif.bright     = bright_q;
  assign vif.vga_r      = rgb_q[11:8];
  assign vif.vga_g      = rgb_q[7:4];
  assign vif.vga_b      = rgb_q[3:0];
  assign vif.frame_tick = pix_en_q & h_last & v_last;

endmodule
